// File: rtl/jtkiwi_shram_pkg.sv
// Shared types and constants for the main/sub shared-RAM responder.
// Build option: define JTKIWI_SHRAM_FAIR_EN for round-robin arbitration
// (default build uses fixed priority, main always wins).
package jtkiwi_shram_pkg;

  localparam int SHRAM_AW = 13;
  localparam int SHRAM_DW = 8;

`ifdef JTKIWI_SHRAM_FAIR_EN
  localparam bit SHRAM_FAIR = 1'b1;
`else
  localparam bit SHRAM_FAIR = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_M = 2'd1,
    GNT_S = 2'd2,
    ACK   = 2'd3
  } state_t;

  typedef enum logic {
    MAIN = 1'b0,
    SUB  = 1'b1
  } side_t;

  // Winner among the pending sides; only meaningful when at least one is pending.
  // On a tie: round-robin gives the side not granted last, fixed priority gives main.
  function automatic side_t arb_pick(input logic pend_m, input logic pend_s, input side_t last);
    side_t pick;
    if (pend_m && pend_s) begin
      pick = (SHRAM_FAIR && (last == MAIN)) ? SUB : MAIN;
    end else begin
      pick = pend_m ? MAIN : SUB;
    end
    return pick;
  endfunction

endpackage

// File: rtl/jtkiwi_shram_if.sv
// One requester port of the shared RAM: level request, direction, address,
// write data, registered read data and a held acknowledge.
interface jtkiwi_shram_if #(
  parameter int AW = jtkiwi_shram_pkg::SHRAM_AW,
  parameter int DW = jtkiwi_shram_pkg::SHRAM_DW
);
  logic          cs;
  logic          rnw;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          ok;

  modport master (output cs, rnw, addr, din, input dout, ok);
  modport slave  (input cs, rnw, addr, din, output dout, ok);
endinterface

// File: rtl/jtkiwi_shram_mem.sv
// Single-port synchronous RAM, registered read data (1-clk latency).
// A read during a write returns the previous contents.
module jtkiwi_shram_mem #(
  parameter int AW = 13,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] ram_q [0:(1<<AW)-1];
  logic [DW-1:0] dout_reg;

  // Block-RAM style port: write on we, always register the read word.
  always_ff @(posedge clk) begin
    if (we) ram_q[addr] <= din;
    dout_reg <= ram_q[addr];
  end

  assign dout = dout_reg;

endmodule

// File: rtl/jtkiwi_shram.sv
// Shared-RAM responder between the main CPU and the sub CPU.
// Rising edge of a side's cs queues a request; a small FSM grants one side at
// a time onto the single-port RAM (IDLE -> GNT_x -> ACK) and returns data/ok.
// Build option: JTKIWI_SHRAM_FAIR_EN selects round-robin arbitration.
module jtkiwi_shram
  import jtkiwi_shram_pkg::*;
#(
  parameter int AW = SHRAM_AW,
  parameter int DW = SHRAM_DW
) (
  input  logic          clk,
  input  logic          rstn,
  jtkiwi_shram_if.slave main_bus,
  jtkiwi_shram_if.slave shr_bus
);

  state_t        state_reg, state_next;
  side_t         last_reg, last_next;
  logic          cs_m_l_reg, cs_s_l_reg;
  logic          pend_m_reg, pend_s_reg;
  logic          main_ok_reg, shr_ok_reg;
  logic [DW-1:0] main_dout_reg, shr_dout_reg;

  logic          rise_m, rise_s;
  logic          pick_m, pick_s;
  logic          ack_m, ack_s;
  logic          done_m, done_s;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;

  assign rise_m = main_bus.cs & ~cs_m_l_reg;
  assign rise_s = shr_bus.cs  & ~cs_s_l_reg;

  // An ACK only completes towards a side that still holds its request.
  assign done_m = ack_m & pend_m_reg & main_bus.cs;
  assign done_s = ack_s & pend_s_reg & shr_bus.cs;

  // Next state and grant. The ACK cycle also serves as the next arbitration
  // slot, so a queued requester is granted without an idle bubble.
  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    ack_m      = 1'b0;
    ack_s      = 1'b0;
    pick_m     = 1'b0;
    pick_s     = 1'b0;
    case (state_reg)
      GNT_M, GNT_S: state_next = ACK;
      ACK: begin
        ack_m      = (last_reg == MAIN);
        ack_s      = (last_reg == SUB);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (state_reg == IDLE || state_reg == ACK) begin
      pick_m = pend_m_reg & main_bus.cs & ~ack_m;
      pick_s = pend_s_reg & shr_bus.cs  & ~ack_s;
      if (pick_m || pick_s) begin
        if (arb_pick(pick_m, pick_s, last_reg) == MAIN) begin
          state_next = GNT_M;
          last_next  = MAIN;
        end else begin
          state_next = GNT_S;
          last_next  = SUB;
        end
      end
    end
  end

  // RAM port steering: only a granted side reaches the memory.
  always_comb begin
    mem_addr = main_bus.addr;
    mem_din  = main_bus.din;
    mem_we   = 1'b0;
    if (state_reg == GNT_S) begin
      mem_addr = shr_bus.addr;
      mem_din  = shr_bus.din;
      mem_we   = ~shr_bus.rnw;
    end else if (state_reg == GNT_M) begin
      mem_we   = ~main_bus.rnw;
    end
  end

  // FSM state and last-grant register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      last_reg  <= SUB;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
    end
  end

  // cs edge detectors and pending flags (cleared on ack or on cs falling).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cs_m_l_reg <= 1'b0;
      cs_s_l_reg <= 1'b0;
      pend_m_reg <= 1'b0;
      pend_s_reg <= 1'b0;
    end else begin
      cs_m_l_reg <= main_bus.cs;
      cs_s_l_reg <= shr_bus.cs;
      if (!main_bus.cs || ack_m) pend_m_reg <= 1'b0;
      else if (rise_m)           pend_m_reg <= 1'b1;
      if (!shr_bus.cs || ack_s)  pend_s_reg <= 1'b0;
      else if (rise_s)           pend_s_reg <= 1'b1;
    end
  end

  // Acknowledge and read-data registers; ok is held until cs drops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      main_ok_reg   <= 1'b0;
      shr_ok_reg    <= 1'b0;
      main_dout_reg <= '0;
      shr_dout_reg  <= '0;
    end else begin
      if (!main_bus.cs) main_ok_reg <= 1'b0;
      else if (done_m)  main_ok_reg <= 1'b1;
      if (!shr_bus.cs)  shr_ok_reg  <= 1'b0;
      else if (done_s)  shr_ok_reg  <= 1'b1;
      if (done_m && main_bus.rnw) main_dout_reg <= mem_dout;
      if (done_s && shr_bus.rnw)  shr_dout_reg  <= mem_dout;
    end
  end

  assign main_bus.ok   = main_ok_reg;
  assign main_bus.dout = main_dout_reg;
  assign shr_bus.ok    = shr_ok_reg;
  assign shr_bus.dout  = shr_dout_reg;

  jtkiwi_shram_mem #(
    .AW (AW),
    .DW (DW)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .addr (mem_addr),
    .din  (mem_din),
    .dout (mem_dout)
  );

endmodule

// File: tb/tb_jtkiwi_shram.sv
// Directed bench for jtkiwi_shram: reset, single accesses, contention,
// back-to-back main traffic against a queued sub request, abandoned write.
module tb_jtkiwi_shram;

  logic clk;
  logic rstn;
  int   vectors;
  int   miscompares;

  jtkiwi_shram_if m_if ();
  jtkiwi_shram_if s_if ();

  jtkiwi_shram dut (
    .clk      (clk),
    .rstn     (rstn),
    .main_bus (m_if),
    .shr_bus  (s_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One uncontended access; lat counts clocks from the edge that first sees cs high to ok.
  task automatic do_access(input bit sub, input bit rnw, input logic [12:0] addr,
                           input logic [7:0] din, output logic [7:0] dout, output int lat);
    bit seen;
    @(negedge clk);
    if (sub) begin s_if.rnw = rnw; s_if.addr = addr; s_if.din = din; s_if.cs = 1'b1; end
    else     begin m_if.rnw = rnw; m_if.addr = addr; m_if.din = din; m_if.cs = 1'b1; end
    @(posedge clk); #1;
    lat  = 0;
    seen = sub ? s_if.ok : m_if.ok;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      seen = sub ? s_if.ok : m_if.ok;
    end
    if (!seen) lat = 99;
    dout = sub ? s_if.dout : m_if.dout;
    $display("%s %s addr=%h din=%h dout=%h lat=%0d", sub ? "sub " : "main",
             rnw ? "rd" : "wr", addr, din, dout, lat);
    @(negedge clk);
    if (sub) s_if.cs = 1'b0; else m_if.cs = 1'b0;
  endtask

  // Both sides raise cs on the same clock (main reads 0x1A5, sub reads 0x0000).
  task automatic dual(output int tm, output int ts, output logic [7:0] dm, output logic [7:0] ds);
    int c;
    tm = -1; ts = -1; dm = '0; ds = '0;
    @(negedge clk);
    m_if.rnw = 1'b1; m_if.addr = 13'h01A5; m_if.cs = 1'b1;
    s_if.rnw = 1'b1; s_if.addr = 13'h0000; s_if.cs = 1'b1;
    @(posedge clk); #1;
    c = 0;
    while ((tm < 0 || ts < 0) && c < 30) begin
      if (m_if.ok && tm < 0) begin tm = c; dm = m_if.dout; end
      if (s_if.ok && ts < 0) begin ts = c; ds = s_if.dout; end
      if (tm < 0 || ts < 0) begin @(posedge clk); #1; c++; end
    end
    $display("dual main_ok@%0d dout=%h sub_ok@%0d dout=%h", tm, dm, ts, ds);
    @(negedge clk);
    m_if.cs = 1'b0; s_if.cs = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] d, dm, ds;
    int lat, tm, ts;
    int main_done, main_issued, sub_at, cyc;
    bit sub_done, main_ack_now, ok_seen;

    vectors = 0; miscompares = 0;
    rstn = 1'b0;
    m_if.cs = 1'b0; m_if.rnw = 1'b1; m_if.addr = '0; m_if.din = '0;
    s_if.cs = 1'b0; s_if.rnw = 1'b1; s_if.addr = '0; s_if.din = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_main_ok",   m_if.ok,   0);
    check("rst_mshramen",  s_if.ok,   0);
    check("rst_main_dout", m_if.dout, 0);
    check("rst_shr_dout",  s_if.dout, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Main write then read back, with exact 3-clock latency.
    do_access(1'b0, 1'b0, 13'h01A5, 8'h3C, d, lat);
    check("t2_wr_lat", lat, 3);
    do_access(1'b0, 1'b1, 13'h01A5, 8'h00, d, lat);
    check("t2_rd_lat", lat, 3);
    check("t2_rd_data", d, 8'h3C);
    @(posedge clk); #1;
    check("t2_ok_fall", m_if.ok, 0);

    // Cross-side visibility at both ends of the address range.
    do_access(1'b1, 1'b0, 13'h0000, 8'h81, d, lat);
    check("t3_sub_wr_lat", lat, 3);
    do_access(1'b0, 1'b1, 13'h0000, 8'h00, d, lat);
    check("t3_main_rd_0000", d, 8'h81);
    do_access(1'b0, 1'b0, 13'h1FFF, 8'h7E, d, lat);
    do_access(1'b1, 1'b1, 13'h1FFF, 8'h00, d, lat);
    check("t3_sub_rd_1fff", d, 8'h7E);
    check("t3_sub_rd_lat", lat, 3);

    // Simultaneous requests, last grant SUB: main first in either arbitration mode.
    dual(tm, ts, dm, ds);
    check("t4a_main_ok_cycle", tm, 3);
    check("t4a_sub_ok_cycle",  ts, 5);
    check("t4a_main_data", dm, 8'h3C);
    check("t4a_sub_data",  ds, 8'h81);

    // Make MAIN the last grant, then collide again.
    do_access(1'b0, 1'b1, 13'h1FFF, 8'h00, d, lat);
    check("t4b_pre_rd", d, 8'h7E);
    dual(tm, ts, dm, ds);
`ifdef JTKIWI_SHRAM_FAIR_EN
    check("t4b_main_ok_cycle", tm, 5);
    check("t4b_sub_ok_cycle",  ts, 3);
`else
    check("t4b_main_ok_cycle", tm, 3);
    check("t4b_sub_ok_cycle",  ts, 5);
`endif

    // Sub queued while main issues 4 back-to-back reads. Main needs cs low for a
    // clock between accesses, so its next rise is never pending when the queued
    // sub is arbitrated: fixed priority costs the sub one main access
    // (main won the initial tie), round-robin serves the sub first (last grant MAIN).
    @(negedge clk);
    m_if.rnw = 1'b1; m_if.addr = 13'h01A5; m_if.cs = 1'b1;
    s_if.rnw = 1'b1; s_if.addr = 13'h0000; s_if.cs = 1'b1;
    main_done = 0; main_issued = 1; sub_done = 1'b0; sub_at = -1; ds = '0;
    cyc = 0;
    while ((main_done < 4 || !sub_done) && cyc < 80) begin
      @(posedge clk); #1;
      cyc++;
      main_ack_now = m_if.ok && m_if.cs;
      if (main_ack_now) begin
        main_done++;
        $display("t5 main ack %0d dout=%h", main_done, m_if.dout);
      end
      if (s_if.ok && s_if.cs && !sub_done) begin
        sub_done = 1'b1; sub_at = main_done; ds = s_if.dout;
        $display("t5 sub ack after %0d main acks dout=%h", sub_at, ds);
      end
      @(negedge clk);
      if (main_ack_now) m_if.cs = 1'b0;
      else if (!m_if.cs && main_issued < 4) begin m_if.cs = 1'b1; main_issued++; end
      if (sub_done) s_if.cs = 1'b0;
    end
    m_if.cs = 1'b0; s_if.cs = 1'b0;
    check("t5_main_done", main_done, 4);
    check("t5_sub_done", int'(sub_done), 1);
    check("t5_sub_data", ds, 8'h81);
`ifdef JTKIWI_SHRAM_FAIR_EN
    check("t5_sub_wait", sub_at, 0);
`else
    check("t5_sub_wait", sub_at, 1);
`endif
    @(negedge clk);

    // Sub write abandoned during GNT_S: write lands, no ack, shr_dout untouched.
    @(negedge clk);
    s_if.rnw = 1'b0; s_if.addr = 13'h0100; s_if.din = 8'h55; s_if.cs = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    s_if.cs = 1'b0;
    ok_seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (s_if.ok) ok_seen = 1'b1;
    end
    $display("t6 sub wr 0100=55 abandoned, ok_seen=%0d", ok_seen);
    check("t6_no_mshramen", int'(ok_seen), 0);
    check("t6_shr_dout_kept", s_if.dout, 8'h81);
    do_access(1'b1, 1'b1, 13'h0100, 8'h00, d, lat);
    check("t6_sub_rd_0100", d, 8'h55);
    do_access(1'b0, 1'b1, 13'h0100, 8'h00, d, lat);
    check("t6_main_rd_0100", d, 8'h55);

    // Asynchronous reset while the FSM is in ACK for a main read.
    @(negedge clk);
    m_if.rnw = 1'b1; m_if.addr = 13'h01A5; m_if.cs = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    $display("t1 async reset asserted mid-ACK");
    check("t1_mid_main_ok",   m_if.ok,   0);
    check("t1_mid_mshramen",  s_if.ok,   0);
    check("t1_mid_main_dout", m_if.dout, 0);
    check("t1_mid_shr_dout",  s_if.dout, 0);
    @(negedge clk);
    m_if.cs = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    do_access(1'b0, 1'b1, 13'h01A5, 8'h00, d, lat);
    check("t1_post_lat", lat, 3);
    check("t1_post_data", d, 8'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
